pipe_hazard_ctrl: RTL and testbench

Sequencer for the four pipeline registers of the RV32I core: IF/ID, ID/EX, EX/MEM and MEM/WB, plus the PC register. It generates per-stage enables and bubble-inject (flush) strobes. It handles load-use stalls, taken-branch flushes, data-memory wait states with a timeout, and an orderly drain-and-halt on ecall/ebreak. It also keeps stall and flush performance counters.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 21 ++
 rtl/pipe_hazard_ctrl_if.sv | 41 ++++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 25 ++
 rtl/pipe_hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_t      : sequencer states RUN / MEMWAIT / DRAIN / HALT
//   IFID..MEMWB  : bit positions of the stage registers in stg_en / stg_flush
//   DRAIN_DEPTH  : unfrozen cycles needed to retire older instructions on halt
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    DRAIN   = 2'd2,
    HALT    = 2'd3
  } state_t;

  localparam int IFID  = 0;
  localparam int IDEX  = 1;
  localparam int EXMEM = 2;
  localparam int MEMWB = 3;

  localparam int DRAIN_DEPTH = 3;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the core datapath and the hazard controller.
//   master : core side, drives the decode/memory status, receives enables
//   slave  : controller side
// Inputs to the controller: ID register indices and usage flags, ID/EX rd and
// load flag, branch resolution, dmem request/ack, halt request.
// Outputs from the controller: PC/stage enables, flush strobes, halted,
// sticky timeout error and the stall/flush performance counters.
interface pipe_hazard_ctrl_if #(
  parameter int REGW = 5,
  parameter int CNTW = 32
);
  logic [REGW-1:0] id_rs1;
  logic [REGW-1:0] id_rs2;
  logic            id_rs1_used;
  logic            id_rs2_used;
  logic [REGW-1:0] ex_rd;
  logic            ex_memread;
  logic            br_taken;
  logic            dmem_req;
  logic            dmem_ack;
  logic            halt_req;
  logic            pc_en;
  logic [3:0]      stg_en;
  logic [3:0]      stg_flush;
  logic            halted;
  logic            err_timeout;
  logic [CNTW-1:0] stall_cnt;
  logic [CNTW-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_memread,
           br_taken, dmem_req, dmem_ack, halt_req,
    input  pc_en, stg_en, stg_flush, halted, err_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_memread,
           br_taken, dmem_req, dmem_ack, halt_req,
    output pc_en, stg_en, stg_flush, halted, err_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use hazard detection.
//   id_rs1/id_rs2, id_rs*_used : source operands of the instruction in ID
//   ex_rd, ex_memread          : destination and load flag of the ID/EX slot
//   lu                         : ID instruction needs the load result now
// x0 is never a real dependency, so a load targeting x0 never stalls.
module pipe_hazard_ctrl_hazard_detect #(
  parameter int REGW = 5
) (
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  logic [REGW-1:0] ex_rd,
  input  logic            ex_memread,
  output logic            lu
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_rs1_used && (id_rs1 == ex_rd);
  assign rs2_hit = id_rs2_used && (id_rs2 == ex_rd);
  assign lu      = ex_memread && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the RV32I core: PC and IF/ID, ID/EX, EX/MEM, MEM/WB
// enables and NOP-inject strobes, load-use stalls, taken-branch flushes,
// dmem wait states with timeout, drain-and-halt on ecall/ebreak, and
// stall/flush performance counters.
//   clk   : core clock
//   rst_n : asynchronous active-low reset
//   bus   : controller side of pipe_hazard_ctrl_if (see interface header)
// Enables and strobes are decoded combinationally from the state and the
// current inputs; state, counters and the error flag are registered.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REGW    = 5,
  parameter int TIMEOUT = 16,
  parameter int CNTW    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int WCW = $clog2(TIMEOUT + 1);

  state_t          state;
  logic [WCW-1:0]  wait_cnt;
  logic [1:0]      drain_cnt;
  logic            err_timeout;
  logic [CNTW-1:0] stall_cnt;
  logic [CNTW-1:0] flush_cnt;

  logic            lu;
  logic            mw;
  logic            pc_en;
  logic [3:0]      stg_en;
  logic [3:0]      stg_flush;
  logic            take_br;
  logic            take_halt;
  logic            wait_expired;

  pipe_hazard_ctrl_hazard_detect #(.REGW(REGW)) u_hazard_detect (
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .id_rs1_used (bus.id_rs1_used),
    .id_rs2_used (bus.id_rs2_used),
    .ex_rd       (bus.ex_rd),
    .ex_memread  (bus.ex_memread),
    .lu          (lu)
  );

  assign mw = bus.dmem_req && !bus.dmem_ack;

  // This wait cycle would be the TIMEOUT-th consecutive one without an ack.
  assign wait_expired = (wait_cnt == WCW'(TIMEOUT - 1));

  always_comb begin
    pc_en     = 1'b1;
    stg_en    = 4'b1111;
    stg_flush = 4'b0000;
    take_br   = 1'b0;
    take_halt = 1'b0;
    unique case (state)
      RUN, MEMWAIT: begin
        // MEMWAIT stays frozen until ack; once acked it decodes like RUN.
        if ((state == RUN && mw) || (state == MEMWAIT && !bus.dmem_ack)) begin
          pc_en  = 1'b0;
          stg_en = 4'b0000;
        end else if (bus.br_taken) begin
          // Killing IF/ID and ID/EX also removes any load-use dependent and
          // any wrong-path halt request, so neither is honoured here.
          stg_flush[IFID] = 1'b1;
          stg_flush[IDEX] = 1'b1;
          take_br         = 1'b1;
        end else if (lu) begin
          pc_en           = 1'b0;
          stg_en[IFID]    = 1'b0;
          stg_flush[IDEX] = 1'b1;
        end else if (bus.halt_req) begin
          pc_en           = 1'b0;
          stg_flush[IFID] = 1'b1;
          take_halt       = 1'b1;
        end
      end
      DRAIN: begin
        pc_en = 1'b0;
        if (mw) stg_en = 4'b0000;
        else    stg_flush[IFID] = 1'b1;
      end
      HALT: begin
        pc_en  = 1'b0;
        stg_en = 4'b0000;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= '0;
      drain_cnt   <= '0;
      err_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      if (!pc_en && state != HALT) stall_cnt <= stall_cnt + 1'b1;
      if (take_br)                 flush_cnt <= flush_cnt + 1'b1;
      unique case (state)
        RUN: begin
          if (mw) begin
            state    <= MEMWAIT;
            wait_cnt <= WCW'(1);
          end else if (take_halt) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        MEMWAIT: begin
          if (bus.dmem_ack) begin
            wait_cnt  <= '0;
            drain_cnt <= '0;
            state     <= take_halt ? DRAIN : RUN;
          end else if (wait_expired) begin
            err_timeout <= 1'b1;
            state       <= HALT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (mw) begin
            if (wait_expired) begin
              err_timeout <= 1'b1;
              state       <= HALT;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end else begin
            wait_cnt <= '0;
            if (drain_cnt == 2'(DRAIN_DEPTH - 1)) state <= HALT;
            else                                  drain_cnt <= drain_cnt + 1'b1;
          end
        end
        HALT: ;
        default: state <= RUN;
      endcase
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.stg_en      = stg_en;
  assign bus.stg_flush   = stg_flush;
  assign bus.halted      = (state == HALT);
  assign bus.err_timeout = err_timeout;
  assign bus.stall_cnt   = stall_cnt;
  assign bus.flush_cnt   = flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use stalls, branch flush,
// dmem wait/ack, dmem timeout, drain-and-halt with a frozen cycle, and
// asynchronous reset in the middle of a memory wait.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REGW(5), .CNTW(32)) bus ();

  pipe_hazard_ctrl #(.REGW(5), .TIMEOUT(16), .CNTW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Step to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_rs1      = '0;
    bus.id_rs2      = '0;
    bus.id_rs1_used = 1'b0;
    bus.id_rs2_used = 1'b0;
    bus.ex_rd       = '0;
    bus.ex_memread  = 1'b0;
    bus.br_taken    = 1'b0;
    bus.dmem_req    = 1'b0;
    bus.dmem_ack    = 1'b0;
    bus.halt_req    = 1'b0;
  endtask

  task automatic check_dec(input string tag, input logic pc, input logic [3:0] en,
                           input logic [3:0] fl);
    #1;
    check({tag, "_pc_en"}, bus.pc_en, pc);
    check({tag, "_stg_en"}, bus.stg_en, en);
    check({tag, "_stg_flush"}, bus.stg_flush, fl);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #3;
    check_dec("rst", 1'b1, 4'b1111, 4'b0000);
    check("rst_halted", bus.halted, 0);
    check("rst_err", bus.err_timeout, 0);
    check("rst_stall", bus.stall_cnt, 0);
    check("rst_flush", bus.flush_cnt, 0);
    #8 rst_n = 1'b1;
    cyc();

    // Load-use via rs1
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.id_rs1_used = 1'b1;
    check_dec("lu_rs1", 1'b0, 4'b1110, 4'b0010);
    cyc();
    check("lu_rs1_stall", bus.stall_cnt, 1);
    // Load into x0 never stalls
    bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0;
    check_dec("lu_x0", 1'b1, 4'b1111, 4'b0000);
    cyc();
    check("lu_x0_stall", bus.stall_cnt, 1);
    // Load-use via rs2
    idle();
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd7; bus.id_rs2 = 5'd7; bus.id_rs2_used = 1'b1;
    check_dec("lu_rs2", 1'b0, 4'b1110, 4'b0010);
    cyc();
    // Matching index but operand not read
    bus.id_rs2_used = 1'b0;
    check_dec("lu_unused", 1'b1, 4'b1111, 4'b0000);
    cyc();
    check("lu_rs2_stall", bus.stall_cnt, 2);

    // Taken branch together with load-use: flush, no stall
    idle();
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.id_rs1_used = 1'b1;
    bus.br_taken = 1'b1;
    check_dec("br_lu", 1'b1, 4'b1111, 4'b0011);
    cyc();
    check("br_flush_cnt", bus.flush_cnt, 1);
    check("br_stall_cnt", bus.stall_cnt, 2);
    idle();

    // dmem wait: 4 frozen cycles then ack
    bus.dmem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_dec($sformatf("mw%0d", i), 1'b0, 4'b0000, 4'b0000);
      cyc();
    end
    bus.dmem_ack = 1'b1;
    check_dec("mw_ack", 1'b1, 4'b1111, 4'b0000);
    cyc();
    idle();
    check_dec("mw_run", 1'b1, 4'b1111, 4'b0000);
    check("mw_stall", bus.stall_cnt, 6);
    check("mw_err", bus.err_timeout, 0);

    // Halt: 1 RUN cycle + 3 unfrozen DRAIN cycles + 1 frozen cycle
    bus.halt_req = 1'b1;
    check_dec("hreq", 1'b0, 4'b1111, 4'b0001);
    cyc();
    idle();
    bus.br_taken = 1'b1;
    check_dec("drain0_br", 1'b0, 4'b1111, 4'b0001);
    cyc();
    idle();
    bus.dmem_req = 1'b1;
    check_dec("drain_mw", 1'b0, 4'b0000, 4'b0000);
    cyc();
    idle();
    check_dec("drain1", 1'b0, 4'b1111, 4'b0001);
    cyc();
    check_dec("drain2", 1'b0, 4'b1111, 4'b0001);
    check("drain2_halted", bus.halted, 0);
    cyc();
    check_dec("halt", 1'b0, 4'b0000, 4'b0000);
    check("halt_halted", bus.halted, 1);
    check("halt_flush_cnt", bus.flush_cnt, 1);
    bus.br_taken = 1'b1;
    cyc(); cyc();
    check("halt_stall", bus.stall_cnt, 11);
    check("halt_hold", bus.halted, 1);
    check_dec("halt_br", 1'b0, 4'b0000, 4'b0000);

    // Reset out of HALT
    #2 rst_n = 1'b0;
    #1;
    check("rst2_halted", bus.halted, 0);
    check("rst2_stall", bus.stall_cnt, 0);
    check("rst2_flush", bus.flush_cnt, 0);
    idle();
    cyc();
    rst_n = 1'b1;
    cyc();

    // dmem timeout
    bus.dmem_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      check($sformatf("to_wait%0d", i), bus.halted, 0);
      check($sformatf("to_err%0d", i), bus.err_timeout, 0);
      cyc();
    end
    #1;
    check("to_halted", bus.halted, 1);
    check("to_err", bus.err_timeout, 1);
    check("to_stall", bus.stall_cnt, 16);
    bus.dmem_ack = 1'b1;
    cyc(); cyc(); cyc();
    check("to_err_hold", bus.err_timeout, 1);
    check("to_halt_hold", bus.halted, 1);
    check("to_stall_hold", bus.stall_cnt, 16);
    idle();
    rst_n = 1'b0;
    #1;
    check("to_rst_err", bus.err_timeout, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Asynchronous reset mid-MEMWAIT
    bus.dmem_req = 1'b1;
    cyc(); cyc(); cyc();
    idle();
    check_dec("mid_mw", 1'b0, 4'b0000, 4'b0000);
    #2 rst_n = 1'b0;
    check_dec("mid_rst", 1'b1, 4'b1111, 4'b0000);
    check("mid_rst_stall", bus.stall_cnt, 0);
    check("mid_rst_halted", bus.halted, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Ack with halt request in MEMWAIT goes to DRAIN
    bus.dmem_req = 1'b1;
    cyc();
    bus.dmem_ack = 1'b1; bus.halt_req = 1'b1;
    check_dec("ack_halt", 1'b0, 4'b1111, 4'b0001);
    cyc();
    idle();
    check_dec("ack_drain", 1'b0, 4'b1111, 4'b0001);
    check("ack_stall", bus.stall_cnt, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
